// File: rtl/picomips_pkg.sv
// Shared types for the picoMIPS board input stage: the operand-capture FSM
// state encoding and the default operand width.
package picomips_pkg;

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_COOL} in_state_t;

  localparam int DW_DEFAULT = 8;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser plus debounce filter for the ready button; accepts a new level after
// DEBOUNCE_CYC agreeing samples (DEBOUNCE_EN), else passes btn_s straight through. No backpressure.
module sync_debounce
  import picomips_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_stable
);

  logic btn_m;
  logic btn_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn_raw;
      btn_s <= btn_m;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [CW-1:0] dcnt;

  // Any sample agreeing with the accepted level restarts the qualification run.
  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt       <= '0;
      btn_stable <= 1'b0;
    end else if (btn_s != btn_stable) begin
      if (dcnt == CW'(DEBOUNCE_CYC - 1)) begin
        btn_stable <= btn_s;
        dcnt       <= '0;
      end else begin
        dcnt <= dcnt + CW'(1);
      end
    end else begin
      dcnt <= '0;
    end
  end
`else
  assign btn_stable = btn_s;
`endif

endmodule

// File: rtl/picomips_input_stage.sv
// Ready-button / switch conditioner feeding the picoMIPS readyin level and x operand (DEBOUNCE_EN selects
// the debounce filter); readyin follows a press after sync+debounce+1 edges, no backpressure from the cpu.
module picomips_input_stage
  import picomips_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int COOLDOWN_CYC = 8,
  parameter int DW           = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_raw,
  input  logic [DW-1:0] sw_data,
  output logic          readyin,
  output logic [DW-1:0] x,
  output logic [3:0]    press_cnt
);

  localparam int CCW = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;

  logic          btn_stable;
  logic [DW-1:0] sw_m;
  logic [DW-1:0] sw_s;

  in_state_t     state, state_n;
  logic [CCW-1:0] cool, cool_n;
  logic          readyin_n;
  logic [DW-1:0] x_n;
  logic [3:0]    press_cnt_n;

  sync_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_sync_debounce (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_stable(btn_stable)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_m      <= '0;
      sw_s      <= '0;
      state     <= S_IDLE;
      cool      <= '0;
      readyin   <= 1'b0;
      x         <= '0;
      press_cnt <= '0;
    end else begin
      sw_m      <= sw_data;
      sw_s      <= sw_m;
      state     <= state_n;
      cool      <= cool_n;
      readyin   <= readyin_n;
      x         <= x_n;
      press_cnt <= press_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cool_n      = cool;
    readyin_n   = readyin;
    x_n         = x;
    press_cnt_n = press_cnt;
    case (state)
      S_IDLE: begin
        readyin_n = 1'b0;
        if (btn_stable) begin
          x_n         = sw_s;
          press_cnt_n = press_cnt + 4'd1;
          readyin_n   = 1'b1;
          state_n     = S_HELD;
        end
      end
      S_HELD: begin
        readyin_n = 1'b1;
        if (!btn_stable) begin
          readyin_n = 1'b0;
          cool_n    = '0;
          state_n   = S_COOL;
        end
      end
      S_COOL: begin
        // Button activity is deliberately ignored until the gap has elapsed.
        readyin_n = 1'b0;
        cool_n    = cool + CCW'(1);
        if (cool == CCW'(COOLDOWN_CYC - 1)) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        readyin_n = 1'b0;
        state_n   = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_picomips_input_stage.sv
// Randomised and directed bench for picomips_input_stage against an event-level reference model;
// works with DEBOUNCE_EN defined or undefined.
module tb_picomips_input_stage;

  localparam int DC = 4;
  localparam int CC = 3;
  localparam int DW = 8;
`ifdef DEBOUNCE_EN
  localparam int LAT = 2 + DC + 1;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_raw = 1'b0;
  logic [DW-1:0] sw_data = '0;
  logic          readyin;
  logic [DW-1:0] x;
  logic [3:0]    press_cnt;

  picomips_input_stage #(
    .DEBOUNCE_CYC(DC),
    .COOLDOWN_CYC(CC),
    .DW          (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .sw_data  (sw_data),
    .readyin  (readyin),
    .x        (x),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: synchroniser as a two-sample delay line, debounce as
  // "last DC samples all oppose the accepted level", press handling as modes.
  logic          m_b1 = 0, m_b2 = 0;
  logic [DW-1:0] m_w1 = '0, m_w2 = '0;
  logic          m_stable = 0;
  bit            hist[$];
  int            m_mode = 0;   // 0 waiting, 1 operand held, 2 cooling down
  int            m_cool_left = 0;
  logic          m_ready = 0;
  logic [DW-1:0] m_x = '0;
  int            m_cnt = 0;

  task automatic model_edge();
    logic eff;
    bit   all_opp;
    if (reset) begin
      m_b1 = 0; m_b2 = 0; m_w1 = '0; m_w2 = '0;
      m_stable = 0; hist.delete();
      m_mode = 0; m_cool_left = 0; m_ready = 0; m_x = '0; m_cnt = 0;
    end else begin
`ifdef DEBOUNCE_EN
      eff = m_stable;
      hist.push_back(m_b2);
      if (hist.size() > DC) void'(hist.pop_front());
      all_opp = (hist.size() == DC);
      foreach (hist[i]) if (hist[i] == m_stable) all_opp = 0;
      if (all_opp) m_stable = !m_stable;
`else
      eff = m_b2;
      all_opp = 0;
`endif
      case (m_mode)
        0: if (eff) begin
             m_x = m_w2; m_cnt = (m_cnt + 1) % 16; m_ready = 1; m_mode = 1;
           end
        1: if (!eff) begin
             m_ready = 0; m_cool_left = CC; m_mode = 2;
           end
        default: begin
          m_cool_left--;
          if (m_cool_left == 0) m_mode = 0;
        end
      endcase
      m_b2 = m_b1; m_b1 = btn_raw;
      m_w2 = m_w1; m_w1 = sw_data;
    end
  endtask

  int   rises = 0;
  logic prev_ready = 0;

  // One clock: drive inputs, advance model, compare outputs at the falling edge.
  task automatic cyc(input logic r, input logic b, input logic [DW-1:0] s);
    reset = r; btn_raw = b; sw_data = s;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("readyin", 32'(readyin), 32'(m_ready));
    chk("x", 32'(x), 32'(m_x));
    chk("press_cnt", 32'(press_cnt), 32'(m_cnt));
    if (readyin === 1'b1 && prev_ready === 1'b0) rises++;
    prev_ready = readyin;
  endtask

  task automatic wait_level(input logic b, input logic [DW-1:0] s, input logic lvl, output int n);
    n = 0;
    while (n < 60) begin
      cyc(0, b, s);
      n++;
      if (readyin === lvl) break;
    end
  endtask

  int n;
  int cnt0;

  initial begin
    @(negedge clk);
    // Reset held with button pressed and switches all ones.
    cyc(1, 1, 8'hFF);
    cyc(1, 1, 8'hFF);
    chk("rst_readyin", 32'(readyin), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_cnt", 32'(press_cnt), 0);
    wait_level(1, 8'hFF, 1, n);
    chk("rst_release_latency", n, LAT);
    chk("rst_release_x", 32'(x), 32'h FF);
    repeat (20) cyc(0, 0, 8'h00);

    // Clean press, then switch changes while held.
    wait_level(1, 8'h05, 1, n);
    chk("press_latency", n, LAT);
    chk("press_x", 32'(x), 32'h05);
    chk("press_cnt2", 32'(press_cnt), 2);
    repeat (8) cyc(0, 1, 8'hFB);
    chk("x_frozen", 32'(x), 32'h05);

    // Release, re-press two cycles after readyin falls.
    wait_level(0, 8'hFB, 0, n);
    chk("release_latency", n, LAT);
    cyc(0, 0, 8'hFB);
    cyc(0, 0, 8'hFB);
    wait_level(1, 8'hFB, 1, n);
    chk("cool_gap_ok", 32'((n + 2) >= (CC + 1)), 1);
    chk("cool_new_x", 32'(x), 32'hFB);
    repeat (20) cyc(0, 0, 8'h11);

    // Short glitch: filtered when debouncing, one pulse when bypassed.
    cnt0 = press_cnt;
    rises = 0;
`ifdef DEBOUNCE_EN
    repeat (3) cyc(0, 1, 8'h22);
`else
    cyc(0, 1, 8'h22);
`endif
    repeat (20) cyc(0, 0, 8'h22);
`ifdef DEBOUNCE_EN
    chk("glitch_rises", rises, 0);
    chk("glitch_cnt", 32'(press_cnt), 32'(cnt0));
    rises = 0;
    for (int i = 0; i < 10; i++) cyc(0, i[0], 8'h33);
    repeat (20) cyc(0, 1, 8'h33);
    chk("toggle_rises", rises, 1);
`else
    chk("glitch_rises", rises, 1);
    chk("glitch_cnt", 32'(press_cnt), 32'((cnt0 + 1) % 16));
    repeat (20) cyc(0, 1, 8'h33);
`endif

    // Reset while readyin is high, button still held afterwards.
    chk("pre_mid_rst_ready", 32'(readyin), 1);
    cyc(1, 1, 8'h44);
    chk("mid_rst_readyin", 32'(readyin), 0);
    chk("mid_rst_x", 32'(x), 0);
    wait_level(1, 8'h44, 1, n);
    chk("mid_rst_reaccept", n, LAT);
    chk("mid_rst_x2", 32'(x), 32'h44);

    // Random bursts against the model, including occasional resets and counter wrap.
    for (int k = 0; k < 400; k++) begin
      logic b;
      logic [DW-1:0] s;
      int run;
      b = 1'($urandom_range(0, 1));
      run = $urandom_range(1, 14);
      s = DW'($urandom);
      for (int j = 0; j < run; j++) begin
        if ($urandom_range(0, 3) == 0) s = DW'($urandom);
        cyc(($urandom_range(0, 299) == 0), b, s);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
